// File: rtl/tnn_kwta_column_if.sv
// tnn_kwta_column_if: run handshake, weight-write port and winner results of the k-WTA column
// Ports (master drives / slave receives):
//   start, k_sel, in_spikes        run request, winners allowed, active-low spike lines
//   wr_en, wr_neuron, wr_syn, wr_data  weight write port (IDLE only)
//   busy, timestep, done            run status
//   win_valid, winners, win_time, fire_mask  results, stable from done until next start
interface tnn_kwta_column_if #(
  parameter int NEURONS = 16,
  parameter int SYNAPSES = 32,
  parameter int WEIGHT_BITS = 3,
  parameter int PERIOD = 8,
  parameter int K = 2
);
  localparam int TW = $clog2(PERIOD);
  localparam int NW = $clog2(NEURONS);
  localparam int KW = $clog2(K + 1);
  localparam int SW = $clog2(SYNAPSES);
  logic start;
  logic [KW-1:0] k_sel;
  logic [SYNAPSES-1:0] in_spikes;
  logic wr_en;
  logic [NW-1:0] wr_neuron;
  logic [SW-1:0] wr_syn;
  logic [WEIGHT_BITS-1:0] wr_data;
  logic busy;
  logic [TW-1:0] timestep;
  logic done;
  logic [K-1:0] win_valid;
  logic [K*NW-1:0] winners;
  logic [K*TW-1:0] win_time;
  logic [NEURONS-1:0] fire_mask;
  modport master (
    output start, k_sel, in_spikes, wr_en, wr_neuron, wr_syn, wr_data,
    input busy, timestep, done, win_valid, winners, win_time, fire_mask
  );
  modport slave (
    input start, k_sel, in_spikes, wr_en, wr_neuron, wr_syn, wr_data,
    output busy, timestep, done, win_valid, winners, win_time, fire_mask
  );
endinterface

// File: rtl/tnn_kwta_column.sv
// tnn_kwta_column: gamma-cycle column of step-no-leak neurons with runtime-k winner-take-all
// Ports: clk, rst (sync, active-high); bus (slave modport of tnn_kwta_column_if) carrying
//   the start/k_sel/in_spikes run inputs, the weight write port and the winner results.
module tnn_kwta_column #(
  parameter int NEURONS = 16,
  parameter int SYNAPSES = 32,
  parameter int WEIGHT_BITS = 3,
  parameter int PERIOD = 8,
  parameter int THRESHOLD = 8,
  parameter int K = 2
) (
  input logic clk,
  input logic rst,
  tnn_kwta_column_if.slave bus
);
  localparam int WMAX = 2**WEIGHT_BITS - 1;
  localparam int PW = $clog2(SYNAPSES*WMAX + 1);
  localparam int TW = $clog2(PERIOD);
  localparam int NW = $clog2(NEURONS);
  localparam int KW = $clog2(K + 1);
  // common width for comparing ramp age against a weight
  localparam int CW = (TW + 1 > WEIGHT_BITS) ? TW + 1 : WEIGHT_BITS;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [KW-1:0] k_q, k_d, cnt_q, cnt_d;
  logic [SYNAPSES-1:0] sv_q, sv_d, sp;
  logic [TW-1:0] ts_q [SYNAPSES];
  logic [TW-1:0] ts_d [SYNAPSES];
  logic [TW-1:0] tse [SYNAPSES];
  logic [CW-1:0] age [SYNAPSES];
  logic [WEIGHT_BITS-1:0] w_q [NEURONS][SYNAPSES];
  logic [PW-1:0] pot [NEURONS];
  logic [NEURONS-1:0] blk_q, blk_d, fm_q, fm_d;
  logic [K-1:0] wv_q, wv_d;
  logic [K*NW-1:0] win_q, win_d;
  logic [K*TW-1:0] wt_q, wt_d;
  // The current cycle's spike sample counts immediately, before it reaches the latch.
  always_comb begin
    for (int s = 0; s < SYNAPSES; s++) begin
      sp[s] = sv_q[s] | (state_q == RUN && !bus.in_spikes[s]);
      tse[s] = sv_q[s] ? ts_q[s] : t_q;
      age[s] = CW'(t_q) - CW'(tse[s]) + CW'(1);
    end
    for (int n = 0; n < NEURONS; n++) begin
      pot[n] = '0;
      for (int s = 0; s < SYNAPSES; s++)
        pot[n] = pot[n] + (sp[s] ? PW'((age[s] < CW'(w_q[n][s])) ? age[s] : CW'(w_q[n][s])) : PW'(0));
    end
  end
  always_comb begin
    state_d = state_q;
    t_d = t_q;
    k_d = k_q;
    cnt_d = cnt_q;
    sv_d = sv_q;
    ts_d = ts_q;
    blk_d = blk_q;
    fm_d = fm_q;
    wv_d = wv_q;
    win_d = win_q;
    wt_d = wt_q;
    if (state_q == IDLE && bus.start) begin
      state_d = RUN;
      t_d = '0;
      k_d = (bus.k_sel == '0) ? KW'(1) : (bus.k_sel > KW'(K)) ? KW'(K) : bus.k_sel;
      cnt_d = '0;
      sv_d = '0;
      blk_d = '0;
      fm_d = '0;
      wv_d = '0;
      win_d = '0;
      wt_d = '0;
    end
    if (state_q == RUN) begin
      sv_d = sp;
      ts_d = tse;
      // Ascending scan gives lower indices priority; every candidate is blocked afterwards,
      // so a crossing neuron that found no free slot stays inhibited.
      for (int n = 0; n < NEURONS; n++) begin
        if (pot[n] >= PW'(THRESHOLD) && !blk_q[n]) begin
          blk_d[n] = 1'b1;
          if (cnt_d < k_q) begin
            for (int j = 0; j < K; j++) begin
              if (cnt_d == KW'(j)) begin
                win_d[j*NW +: NW] = NW'(n);
                wt_d[j*TW +: TW] = t_q;
                wv_d[j] = 1'b1;
              end
            end
            fm_d[n] = 1'b1;
            cnt_d = cnt_d + KW'(1);
          end
        end
      end
      state_d = (t_q == TW'(PERIOD - 1)) ? DONE : RUN;
      t_d = (t_q == TW'(PERIOD - 1)) ? '0 : t_q + TW'(1);
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q <= '0;
      k_q <= '0;
      cnt_q <= '0;
      sv_q <= '0;
      blk_q <= '0;
      fm_q <= '0;
      wv_q <= '0;
      win_q <= '0;
      wt_q <= '0;
      for (int s = 0; s < SYNAPSES; s++) ts_q[s] <= '0;
      for (int n = 0; n < NEURONS; n++)
        for (int s = 0; s < SYNAPSES; s++) w_q[n][s] <= '0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      k_q <= k_d;
      cnt_q <= cnt_d;
      sv_q <= sv_d;
      blk_q <= blk_d;
      fm_q <= fm_d;
      wv_q <= wv_d;
      win_q <= win_d;
      wt_q <= wt_d;
      ts_q <= ts_d;
      if (state_q == IDLE && bus.wr_en) w_q[bus.wr_neuron][bus.wr_syn] <= bus.wr_data;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.timestep = t_q;
  assign bus.done = state_q == DONE;
  assign bus.win_valid = wv_q;
  assign bus.winners = win_q;
  assign bus.win_time = wt_q;
  assign bus.fire_mask = fm_q;
endmodule

// File: tb/tb_tnn_kwta_column.sv
// tb_tnn_kwta_column: directed table-driven bench for the k-WTA column
module tb_tnn_kwta_column;
  localparam int N = 16, S = 32, WB = 3, P = 8, TH = 8, K = 2;
  localparam int NW = 4, TW = 3, KW = 2, SW = 5;
  typedef struct {
    int k;
    int ta, tb, tc, td;
    bit pulse;
    logic [1:0] wv;
    int w0, t0, w1, t1;
    logic [15:0] fm;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int nchk = 0, nerr = 0;
  vec_t vt[14];
  vec_t v;
  always #5 clk = ~clk;
  tnn_kwta_column_if #(.NEURONS(N), .SYNAPSES(S), .WEIGHT_BITS(WB), .PERIOD(P), .K(K)) b();
  tnn_kwta_column #(.NEURONS(N), .SYNAPSES(S), .WEIGHT_BITS(WB), .PERIOD(P), .THRESHOLD(TH), .K(K))
    dut (.clk(clk), .rst(rst), .bus(b));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // group A = syn 0..7 and 23..31, B = 8..11, C = 12..19, D = 20..22; -1 means never spikes
  function automatic logic [S-1:0] spikes(input vec_t x, input int t);
    logic [S-1:0] r;
    int g;
    for (int s = 0; s < S; s++) begin
      g = (s < 8 || s >= 23) ? x.ta : (s < 12) ? x.tb : (s < 20) ? x.tc : x.td;
      r[s] = !(g >= 0 && (x.pulse ? t == g : t >= g));
    end
    return r;
  endfunction
  task automatic wr(input int n, input int s, input int d);
    @(negedge clk);
    b.wr_en = 1'b1;
    b.wr_neuron = NW'(n);
    b.wr_syn = SW'(s);
    b.wr_data = WB'(d);
    @(negedge clk);
    b.wr_en = 1'b0;
  endtask
  task automatic check_results(input string name, input vec_t x);
    chk({name, " win_valid"}, 32'(b.win_valid), 32'(x.wv));
    chk({name, " winners"}, 32'(b.winners), {24'd0, NW'(x.w1), NW'(x.w0)});
    chk({name, " win_time"}, 32'(b.win_time), {26'd0, TW'(x.t1), TW'(x.t0)});
    chk({name, " fire_mask"}, 32'(b.fire_mask), 32'(x.fm));
  endtask
  // mode 0 plain run, 1 start+write pulsed mid-run, 2 write N3/syn0=0 with start, 3 reset at t=3
  task automatic run(input string name, input vec_t x, input int mode);
    int dn;
    @(negedge clk);
    b.start = 1'b1;
    b.k_sel = KW'(x.k);
    if (mode == 2) begin
      b.wr_en = 1'b1;
      b.wr_neuron = NW'(3);
      b.wr_syn = '0;
      b.wr_data = '0;
    end
    @(negedge clk);
    b.start = 1'b0;
    b.wr_en = 1'b0;
    for (int t = 0; t < P; t++) begin
      chk({name, " timestep"}, 32'(b.timestep), 32'(t));
      chk({name, " busy/done in run"}, {30'd0, b.busy, b.done}, 32'd2);
      b.in_spikes = spikes(x, t);
      b.start = (mode == 1 && t == 2);
      b.wr_en = (mode == 1 && t == 2);
      b.wr_neuron = NW'(3);
      b.wr_syn = '0;
      b.wr_data = '0;
      if (mode == 3 && t == 3) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        b.in_spikes = '1;
        chk({name, " busy/done after rst"}, {30'd0, b.busy, b.done}, 32'd0);
        chk({name, " timestep after rst"}, 32'(b.timestep), 32'd0);
        check_results({name, " after rst"}, '{0, -1, -1, -1, -1, 0, 2'b00, 0, 0, 0, 0, 16'h0});
        dn = 0;
        for (int c = 0; c < P + 4; c++) begin
          @(negedge clk);
          dn += int'(b.done);
        end
        chk({name, " no done after rst"}, 32'(dn), 32'd0);
        return;
      end
      @(negedge clk);
    end
    b.in_spikes = '1;
    b.start = 1'b0;
    b.wr_en = 1'b0;
    chk({name, " done pulse"}, {30'd0, b.busy, b.done}, 32'd3);
    check_results(name, x);
    @(negedge clk);
    chk({name, " back to idle"}, {30'd0, b.busy, b.done}, 32'd0);
    check_results({name, " held"}, x);
  endtask
  initial begin
    b.start = 1'b0;
    b.k_sel = '0;
    b.in_spikes = '1;
    b.wr_en = 1'b0;
    b.wr_neuron = '0;
    b.wr_syn = '0;
    b.wr_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset busy/done", {30'd0, b.busy, b.done}, 32'd0);
    chk("reset timestep", 32'(b.timestep), 32'd0);
    check_results("reset", '{0, -1, -1, -1, -1, 0, 2'b00, 0, 0, 0, 0, 16'h0});
    run("zero weights", '{2, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0}, 0);
    for (int s = 0; s < 8; s++) wr(3, s, 7);
    for (int s = 8; s < 12; s++) begin
      wr(2, s, 2);
      wr(5, s, 2);
    end
    for (int s = 12; s < 20; s++) wr(4, s, 1);
    for (int s = 20; s < 23; s++) begin
      wr(1, s, 7);
      wr(6, s, 7);
    end
    vt[0]  = '{1,  0, -1, -1, -1, 0, 2'b01, 3, 0, 0, 0, 16'h0008};
    vt[1]  = '{1, -1,  0, -1, -1, 0, 2'b01, 2, 1, 0, 0, 16'h0004};
    vt[2]  = '{2, -1,  0, -1, -1, 0, 2'b11, 2, 1, 5, 1, 16'h0024};
    vt[3]  = '{2, -1, -1,  0,  0, 0, 2'b11, 4, 0, 1, 2, 16'h0012};
    vt[4]  = '{0, -1, -1,  0,  0, 0, 2'b01, 4, 0, 0, 0, 16'h0010};
    vt[5]  = '{3, -1, -1,  0,  0, 0, 2'b11, 4, 0, 1, 2, 16'h0012};
    vt[6]  = '{2,  5, -1, -1, -1, 0, 2'b01, 3, 5, 0, 0, 16'h0008};
    vt[7]  = '{2,  7, -1, -1, -1, 0, 2'b01, 3, 7, 0, 0, 16'h0008};
    vt[8]  = '{2, -1,  0, -1, -1, 1, 2'b11, 2, 1, 5, 1, 16'h0024};
    vt[9]  = '{1,  0, -1,  0, -1, 0, 2'b01, 3, 0, 0, 0, 16'h0008};
    vt[10] = '{2,  0, -1,  0, -1, 0, 2'b11, 3, 0, 4, 0, 16'h0018};
    vt[11] = '{2, -1, -1, -1, -1, 0, 2'b00, 0, 0, 0, 0, 16'h0000};
    vt[12] = '{2, -1, -1, -1,  3, 0, 2'b11, 1, 5, 6, 5, 16'h0042};
    vt[13] = '{2,  2,  0, -1, -1, 0, 2'b11, 2, 1, 5, 1, 16'h0024};
    for (int i = 0; i < 14; i++) run($sformatf("vec%0d", i), vt[i], 0);
    run("busy start+write", vt[0], 1);
    run("weight kept", vt[0], 0);
    v = vt[0];
    v.t0 = 1;
    run("write with start", v, 2);
    wr(3, 0, 7);
    run("weight restored", vt[0], 0);
    run("mid-run reset", vt[10], 3);
    run("weights cleared", '{2, 0, -1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 16'h0}, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
